// File: rtl/tl_pkg.sv
// Shared types, lamp codes and helpers for the intersection phase sequencer.
package tl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LAMP_W  = 3;
  localparam int unsigned INIT_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALL_RED_A = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALL_RED_B = 3'd5,
    FLASH     = 3'd6
  } state_e;

  // Lamp codes are {red, yellow, green}
  localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;
  localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

  // Bit positions within the one-hot counter load
  localparam int unsigned GREEN  = 0;
  localparam int unsigned YELLOW = 1;
  localparam int unsigned RED    = 2;

  typedef struct packed {
    logic [LAMP_W-1:0] a;
    logic [LAMP_W-1:0] b;
    logic              walk;
  } lamps_t;

  // Counter load pattern for a state; clearance phases reuse the yellow time.
  function automatic logic [INIT_W-1:0] init_code(state_e s);
    logic [INIT_W-1:0] code;
    code = '0;
    case (s)
      A_GREEN, B_GREEN:                         code[GREEN]  = 1'b1;
      A_YELLOW, B_YELLOW, ALL_RED_A, ALL_RED_B: code[YELLOW] = 1'b1;
      default:                                  code = '0;
    endcase
    return code;
  endfunction

  function automatic lamps_t lamps_for(state_e s, logic flash_ph);
    lamps_t l;
    l = '{a: LAMP_RED, b: LAMP_RED, walk: 1'b0};
    case (s)
      A_GREEN:  l.a = LAMP_GRN;
      A_YELLOW: l.a = LAMP_YEL;
      B_GREEN: begin
        l.b    = LAMP_GRN;
        l.walk = 1'b1;
      end
      B_YELLOW: l.b = LAMP_YEL;
      FLASH: begin
        l.a = flash_ph ? LAMP_YEL : LAMP_OFF;
        l.b = flash_ph ? LAMP_RED : LAMP_OFF;
      end
      default: l = '{a: LAMP_RED, b: LAMP_RED, walk: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_sequencer.sv
// Two-road intersection phase sequencer: drives the shared phase counter
// through load pulses and count enable, and registers the lamp outputs.
module tl_phase_sequencer
  import tl_pkg::*;
#(
  parameter int unsigned pINIT_WIDTH  = 3,
  parameter int unsigned pSTATE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    last,
  input  logic                    b_req,
  input  logic                    ped_req,
  input  logic                    night,
  output logic [pINIT_WIDTH-1:0]  init,
  output logic                    cnt_en,
  output logic [2:0]              a_lights,
  output logic [2:0]              b_lights,
  output logic                    walk,
  output logic [pSTATE_WIDTH-1:0] state
);

  state_e state_q, state_d;
  logic   load_q, load_d;
  logic   ped_pend_q, ped_pend_d;
  logic   flash_ph_q, flash_ph_d;
  lamps_t lamps_q, lamps_d;

  // Next-state, pedestrian latch, flash phase and lamp decode
  always_comb begin
    state_d    = state_q;
    load_d     = 1'b0;
    ped_pend_d = ped_pend_q;
    flash_ph_d = flash_ph_q;

    if (state_q == FLASH) begin
      if (tick) begin
        if (!night) begin
          state_d = ALL_RED_B;
        end else begin
          flash_ph_d = ~flash_ph_q;
        end
      end
      load_d = (state_d != FLASH);
    end else if (!load_q && last) begin
      case (state_q)
        A_GREEN:   state_d = (b_req || ped_pend_q) ? A_YELLOW : A_GREEN;
        A_YELLOW:  state_d = ALL_RED_A;
        ALL_RED_A: state_d = night ? FLASH : B_GREEN;
        B_GREEN:   state_d = B_YELLOW;
        B_YELLOW:  state_d = ALL_RED_B;
        ALL_RED_B: state_d = night ? FLASH : A_GREEN;
        default:   state_d = ALL_RED_B;
      endcase
      // Every phase end re-arms the counter, including A_GREEN re-entry
      load_d = (state_d != FLASH);
    end

    if (state_d inside {B_GREEN, FLASH}) begin
      ped_pend_d = 1'b0;
    end else if (ped_req && !(state_q inside {B_GREEN, FLASH})) begin
      ped_pend_d = 1'b1;
    end

    if (state_d == FLASH && state_q != FLASH) begin
      flash_ph_d = 1'b0;
    end

    lamps_d = lamps_for(state_d, flash_ph_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ALL_RED_B;
      load_q     <= 1'b1;
      ped_pend_q <= 1'b0;
      flash_ph_q <= 1'b0;
      lamps_q    <= '{a: LAMP_RED, b: LAMP_RED, walk: 1'b0};
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      ped_pend_q <= ped_pend_d;
      flash_ph_q <= flash_ph_d;
      lamps_q    <= lamps_d;
    end
  end

  // Counter controls: load pulse on the first cycle of a phase, then follow tick
  always_comb begin
    init   = '0;
    cnt_en = 1'b0;
    if (!rst && state_q != FLASH) begin
      if (load_q) begin
        init = pINIT_WIDTH'(init_code(state_q));
      end else begin
        cnt_en = tick;
      end
    end
  end

  assign a_lights = lamps_q.a;
  assign b_lights = lamps_q.b;
  assign walk     = lamps_q.walk;
  assign state    = pSTATE_WIDTH'(state_q);

endmodule

// File: doc/tl_phase_sequencer.md
# tl_phase_sequencer

Phase sequencer for a two-road intersection (main road A, side road B). It drives the shared phase countdown counter through one-hot `init` load pulses and a count `en`, and advances its state machine on the counter's `last` flag. It produces the A/B lamp outputs and the pedestrian walk signal, and it sits between the 1 Hz tick generator and the lamp drivers in the intersection top level.

## Interface
- pINIT_WIDTH, 3: width of `init`; bit 0 loads green time, bit 1 loads yellow time, bit 2 loads red time.
- pSTATE_WIDTH, 3: width of the debug `state` output.

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  one-cycle count-enable strobe (1 Hz in the system)
- last  in  1  phase counter has reached 0
- b_req  in  1  side-road vehicle sensor, level
- ped_req  in  1  pedestrian button, single-cycle pulse
- night  in  1  flash-mode request, level
- init  out  pINIT_WIDTH  one-hot counter load, single-cycle pulse
- cnt_en  out  1  counter decrement enable
- a_lights  out  3  A lamps {red, yellow, green}
- b_lights  out  3  B lamps {red, yellow, green}
- walk  out  1  pedestrian walk lamp (crossing road A)
- state  out  pSTATE_WIDTH  current state, debug

## Operation
- States and their init codes:
  - A_GREEN: green
  - A_YELLOW: yellow
  - ALL_RED_A: yellow code; clearance after A
  - B_GREEN: green
  - B_YELLOW: yellow
  - ALL_RED_B: yellow code; clearance after B
  - FLASH: no counter use
- Load cycle: the first cycle in any non-FLASH state, including re-entry to the same state.
  - `init` is asserted with that state's code.
  - `cnt_en` is 0.
  - `last` is ignored during the load cycle.
- After the load cycle, `cnt_en` = `tick`. The phase ends on the first cycle with `last`=1.
- Phase-end transitions:
  - A_GREEN → A_YELLOW if `b_req` or `ped_pend` is set. Otherwise re-enter A_GREEN; the new load cycle re-arms green and the lamps stay green.
  - A_YELLOW → ALL_RED_A.
  - ALL_RED_A → FLASH if `night`, else B_GREEN.
  - B_GREEN → B_YELLOW.
  - B_YELLOW → ALL_RED_B.
  - ALL_RED_B → FLASH if `night`, else A_GREEN.
- `ped_pend` latch:
  - Set by `ped_req` in any state except B_GREEN and FLASH.
  - Cleared on entry to B_GREEN.
  - `ped_req` in the cycle B_GREEN is entered is discarded.
- Lamps:
  - A_GREEN: A=001, B=100.
  - A_YELLOW: A=010, B=100.
  - ALL_RED_*: A=100, B=100.
  - B_GREEN: A=100, B=001, `walk`=1.
  - B_YELLOW: A=100, B=010.
- FLASH:
  - `init`=0, `cnt_en`=0, `ped_pend` held cleared.
  - `flash_ph` toggles on each `tick`.
  - When `flash_ph`=1: A=010, B=100. When `flash_ph`=0: A=000, B=000.
  - `walk`=0.
  - On a `tick` with `night`=0 → ALL_RED_B; the load cycle follows, then A_GREEN.
  - `flash_ph` clears on FLASH entry.
- Reset:
  - state=ALL_RED_B with the load cycle pending.
  - `init`=0, `cnt_en`=0, A=100, B=100, `walk`=0.
  - `ped_pend`=0, `flash_ph`=0.
  - Reset mid-phase abandons the phase. The first cycle after reset is an ALL_RED_B load cycle (`init`=010).
- `init` is never multi-hot. No lamp output ever shows green on A and B at the same time.

## Timing
- All outputs are registered from state. `init` and `cnt_en` are combinational from registered state plus `tick`.
- With `tick` held at 1 and a loaded count N, a phase lasts N+2 cycles:
  - 1 load cycle;
  - N decrement cycles;
  - 1 cycle with `last`=1, after which the state changes on the next edge.
- With a sparse `tick`, a phase lasts 1 load cycle + N ticks + 1 cycle.
- Lamp outputs change on the same edge as the state.

## Structure
- Shared package `tl_pkg` holds:
  - the state enum;
  - the lamp codes LAMP_RED=100, LAMP_YEL=010, LAMP_GRN=001, LAMP_OFF=000;
  - the init bit indices GREEN=0, YELLOW=1, RED=2.
- No sub-module. The block does not instantiate the phase counter; the top level connects them and inverts `rst` for the counter's active-low reset.

## Test plan
- Reset, `tick`=1, counter green=15, yellow=3:
  - `init`=010 in cycle 1;
  - A_GREEN entered at cycle 6 (3+2);
  - A_GREEN lasts 17 cycles.
- `b_req`=0, no pedestrian request: A_GREEN re-enters repeatedly. Each re-entry pulses `init`=001 and `a_lights` stays 001 with no glitch.
- `ped_req` pulse mid A_GREEN: `walk`=1 for the whole B_GREEN. A second `ped_req` during B_GREEN is not re-served on the next cycle.
- `night`=1 raised during B_GREEN:
  - the sequence completes B_YELLOW and ALL_RED_B, then enters FLASH;
  - A/B alternate 010/100 and 000/000 on each tick.
  - Dropping `night` gives ALL_RED_B then A_GREEN.
- `rst` pulse mid B_YELLOW: the next cycle shows ALL_RED_B with `init`=010 and both roads red.
- Stale `last`=1 held during a load cycle produces no transition.
